// File: rtl/battleship_pkg.sv
// Shared types and constants for the battleship turn sequencer:
// FSM state encoding, board size, coordinate type and LFSR constants.
package battleship_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PLACE  = 3'd1,
      P_TURN = 3'd2,
      P_SHOT = 3'd3,
      E_WAIT = 3'd4,
      E_SHOT = 3'd5,
      WIN    = 3'd6,
      LOSE   = 3'd7
   } state_t;

   localparam int BOARD_N = 5;

   typedef logic [2:0] coord_t;

   // Galois LFSR for x^8+x^6+x^5+x^4+1, right-shifting form
   localparam logic [7:0] LFSR_SEED = 8'h5A;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Galois LFSR used as the enemy's coordinate source.
// Advances every clock; reset reloads the seed.
module lfsr8
   import battleship_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] q
);

   // shift right, fold the taps in whenever a one falls off the bottom
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= LFSR_SEED;
      end else begin
         q <= {1'b0, q[7:1]} ^ (q[0] ? LFSR_TAPS : 8'h00);
      end
   end

endmodule

// File: rtl/turn_sequencer.sv
// Battleship turn sequencer: placement, player turn with optional
// timeout, player shot, enemy think delay, enemy shot and win/loss.
// Build option: define TURN_TIMEOUT_EN to enable the player turn timer;
// without it the player waits indefinitely and timer reads 0.
module turn_sequencer #(
   parameter int BOARD_N      = battleship_pkg::BOARD_N,
   parameter int TURN_SECS    = 10,
   parameter int E_DELAY_SECS = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   tick_1hz,
   input  logic                   place_done,
   input  logic                   confirm,
   input  battleship_pkg::coord_t cur_x,
   input  battleship_pkg::coord_t cur_y,
   input  logic [2:0]             p_ships_left,
   input  logic [2:0]             e_ships_left,
   input  logic                   shot_ack,
   input  logic                   shot_repeat,
   output logic                   shot_valid,
   output logic                   shot_to_enemy,
   output battleship_pkg::coord_t shot_x,
   output battleship_pkg::coord_t shot_y,
   output logic [2:0]             state,
   output logic [3:0]             timer,
   output logic                   game_over,
   output logic                   winner
);
   import battleship_pkg::*;

   localparam logic [3:0] BOARD_LIM = 4'(BOARD_N);
   localparam logic [3:0] TURN_LOAD = 4'(TURN_SECS);
   localparam logic [7:0] E_DELAY   = 8'(E_DELAY_SECS);

   logic [7:0] lfsr_q;
   state_t     state_reg;
   logic [7:0] e_cnt_reg;
   logic       cursor_ok;
   logic       enemy_ok;
   logic       delay_done;

   lfsr8 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .q     (lfsr_q)
   );

   assign cursor_ok  = ({1'b0, cur_x} < BOARD_LIM) && ({1'b0, cur_y} < BOARD_LIM);
   assign enemy_ok   = ({1'b0, lfsr_q[2:0]} < BOARD_LIM) && ({1'b0, lfsr_q[5:3]} < BOARD_LIM);
   assign delay_done = (e_cnt_reg >= E_DELAY);
   assign state      = state_reg;

`ifdef TURN_TIMEOUT_EN
   logic unused_bits;
   assign unused_bits = ^lfsr_q[7:6];
`else
   // no countdown hardware: the turn never expires
   logic unused_bits;
   assign unused_bits = ^{TURN_LOAD, lfsr_q[7:6]};
   assign timer       = 4'd0;
`endif

   // game FSM with registered shot request, timer and result outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         e_cnt_reg     <= 8'd0;
         shot_valid    <= 1'b0;
         shot_to_enemy <= 1'b0;
         shot_x        <= '0;
         shot_y        <= '0;
         game_over     <= 1'b0;
         winner        <= 1'b0;
`ifdef TURN_TIMEOUT_EN
         timer         <= 4'd0;
`endif
      end else begin
         case (state_reg)
            IDLE: state_reg <= PLACE;

            PLACE: begin
               if (place_done) begin
                  state_reg <= P_TURN;
`ifdef TURN_TIMEOUT_EN
                  timer     <= TURN_LOAD;
`endif
               end
            end

            P_TURN: begin
               // result checks outrank confirm and timeout
               if (e_ships_left == 3'd0) begin
                  state_reg <= WIN;
                  game_over <= 1'b1;
                  winner    <= 1'b1;
               end else if (p_ships_left == 3'd0) begin
                  state_reg <= LOSE;
                  game_over <= 1'b1;
                  winner    <= 1'b0;
               end else if (confirm && cursor_ok) begin
                  // confirm also beats an expiring tick in the same cycle
                  state_reg     <= P_SHOT;
                  shot_valid    <= 1'b1;
                  shot_to_enemy <= 1'b1;
                  shot_x        <= cur_x;
                  shot_y        <= cur_y;
               end
`ifdef TURN_TIMEOUT_EN
               else if (tick_1hz) begin
                  if (timer <= 4'd1) begin
                     timer     <= 4'd0;
                     state_reg <= E_WAIT;
                     e_cnt_reg <= 8'd0;
                  end else begin
                     timer <= timer - 4'd1;
                  end
               end
`endif
            end

            P_SHOT: begin
               if (shot_ack) begin
                  shot_valid <= 1'b0;
                  if (shot_repeat) begin
                     // same turn again, clock keeps its remaining time
                     state_reg <= P_TURN;
                  end else begin
                     state_reg <= E_WAIT;
                     e_cnt_reg <= 8'd0;
                  end
               end
            end

            E_WAIT: begin
               if (e_ships_left == 3'd0) begin
                  state_reg <= WIN;
                  game_over <= 1'b1;
                  winner    <= 1'b1;
               end else if (p_ships_left == 3'd0) begin
                  state_reg <= LOSE;
                  game_over <= 1'b1;
                  winner    <= 1'b0;
               end else if (!delay_done) begin
                  if (tick_1hz) begin
                     e_cnt_reg <= e_cnt_reg + 8'd1;
                  end
               end else if (enemy_ok) begin
                  // otherwise retry next cycle with the next LFSR value
                  state_reg     <= E_SHOT;
                  shot_valid    <= 1'b1;
                  shot_to_enemy <= 1'b0;
                  shot_x        <= lfsr_q[2:0];
                  shot_y        <= lfsr_q[5:3];
               end
            end

            E_SHOT: begin
               if (shot_ack) begin
                  shot_valid <= 1'b0;
                  if (shot_repeat) begin
                     // think delay already served: pick again right away
                     state_reg <= E_WAIT;
                     e_cnt_reg <= E_DELAY;
                  end else begin
                     state_reg <= P_TURN;
`ifdef TURN_TIMEOUT_EN
                     timer     <= TURN_LOAD;
`endif
                  end
               end
            end

            WIN, LOSE: state_reg <= state_reg;

            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: player shots go through a
// scoreboard queue; enemy shots are checked against an LFSR model.
module tb_turn_sequencer;

   localparam logic [2:0] S_IDLE = 3'd0, S_PLACE = 3'd1, S_P_TURN = 3'd2, S_P_SHOT = 3'd3,
                          S_E_WAIT = 3'd4, S_E_SHOT = 3'd5, S_WIN = 3'd6, S_LOSE = 3'd7;
`ifdef TURN_TIMEOUT_EN
   localparam bit TMO = 1'b1;
`else
   localparam bit TMO = 1'b0;
`endif
   localparam logic [3:0] RELOAD = TMO ? 4'd10 : 4'd0;

   typedef struct packed {
      logic       to_enemy;
      logic [2:0] x;
      logic [2:0] y;
   } shot_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick_1hz = 1'b0, place_done = 1'b0, confirm = 1'b0;
   logic [2:0] cur_x = '0, cur_y = '0;
   logic [2:0] p_ships_left = 3'd5, e_ships_left = 3'd5;
   logic       shot_ack = 1'b0, shot_repeat = 1'b0;
   logic       shot_valid, shot_to_enemy, game_over, winner;
   logic [2:0] shot_x, shot_y, state;
   logic [3:0] timer;

   int    checks = 0;
   int    failures = 0;
   shot_t exp_q[$];
   logic [7:0] m_lfsr, m_prev;

   turn_sequencer dut (
      .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .place_done(place_done),
      .confirm(confirm), .cur_x(cur_x), .cur_y(cur_y),
      .p_ships_left(p_ships_left), .e_ships_left(e_ships_left),
      .shot_ack(shot_ack), .shot_repeat(shot_repeat),
      .shot_valid(shot_valid), .shot_to_enemy(shot_to_enemy),
      .shot_x(shot_x), .shot_y(shot_y), .state(state), .timer(timer),
      .game_over(game_over), .winner(winner)
   );

   always #20 clk = ~clk;

   // reference LFSR: x^8+x^6+x^5+x^4+1 Galois, m_prev holds the value seen at the last edge
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_lfsr <= 8'h5A;
         m_prev <= 8'h5A;
      end else begin
         m_prev <= m_lfsr;
         m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic pulse_tick();
      tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0;
   endtask

   task automatic ack(input logic rep);
      shot_ack = 1'b1; shot_repeat = rep; cyc(); shot_ack = 1'b0; shot_repeat = 1'b0;
   endtask

   task automatic wait_state(input logic [2:0] target, input int budget, output bit ok);
      int n = 0;
      while (state !== target && n < budget) begin
         cyc();
         n++;
      end
      ok = (state === target);
   endtask

   // reset, release, and enter P_TURN
   task automatic go_pturn();
      reset = 1'b0; place_done = 1'b0; confirm = 1'b0; tick_1hz = 1'b0;
      shot_ack = 1'b0; p_ships_left = 3'd5; e_ships_left = 3'd5;
      repeat (2) cyc();
      reset = 1'b1;
      cyc();
      place_done = 1'b1;
      cyc();
      checks++;
      if (state !== S_P_TURN) begin
         failures++;
         $display("FAIL enter_pturn: state=%0d required=%0d", state, S_P_TURN);
      end
   endtask

   // player confirm; expected request goes on the scoreboard and is popped when shot_valid appears
   task automatic fire(input logic [2:0] x, input logic [2:0] y);
      int    n = 0;
      shot_t got, exp;
      cur_x = x; cur_y = y;
      exp_q.push_back({1'b1, x, y});
      confirm = 1'b1; cyc(); confirm = 1'b0;
      while (!shot_valid && n < 8) begin cyc(); n++; end
      checks++;
      if (!shot_valid) begin
         failures++;
         $display("FAIL player_shot_timeout: shot_valid=%0b required=1", shot_valid);
         void'(exp_q.pop_front());
      end else begin
         exp = exp_q.pop_front();
         got = {shot_to_enemy, shot_x, shot_y};
         if (got !== exp || state !== S_P_SHOT) begin
            failures++;
            $display("FAIL player_shot: dest=%0b (%0d,%0d) state=%0d required dest=%0b (%0d,%0d) state=%0d",
                     got.to_enemy, got.x, got.y, state, exp.to_enemy, exp.x, exp.y, S_P_SHOT);
         end
      end
   endtask

   // from E_WAIT: optional tick, then the enemy request must appear with model-predicted coords
   task automatic enemy_shot(input bit give_tick, input int idx);
      bit ok;
      if (give_tick) pulse_tick();
      wait_state(S_E_SHOT, 300, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL enemy_wait: state=%0d required=%0d", state, S_E_SHOT);
      end else if (shot_valid !== 1'b1 || shot_to_enemy !== 1'b0 || shot_x >= 3'd5 || shot_y >= 3'd5 ||
                   shot_x !== m_prev[2:0] || shot_y !== m_prev[5:3]) begin
         failures++;
         $display("FAIL enemy_shot: valid=%0b dest=%0b (%0d,%0d) required valid=1 dest=0 (%0d,%0d)",
                  shot_valid, shot_to_enemy, shot_x, shot_y, m_prev[2:0], m_prev[5:3]);
      end else begin
         $display("enemy shot %0d: (%0d,%0d)", idx, shot_x, shot_y);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1 reset = 1'b0;
      cyc();
      checks++;
      if (state !== S_IDLE || timer !== 4'd0 || shot_valid !== 1'b0 || shot_to_enemy !== 1'b0 ||
          shot_x !== 3'd0 || shot_y !== 3'd0 || game_over !== 1'b0 || winner !== 1'b0 ||
          dut.u_lfsr.q !== 8'h5A) begin
         failures++;
         $display("FAIL reset_outputs: state=%0d timer=%0d valid=%0b lfsr=%h required 0/0/0 lfsr=5a",
                  state, timer, shot_valid, dut.u_lfsr.q);
      end
      reset = 1'b1;
      cyc();
      checks++;
      if (state !== S_PLACE) begin
         failures++;
         $display("FAIL idle_to_place: state=%0d required=%0d", state, S_PLACE);
      end
      repeat (3) cyc();
      checks++;
      if (state !== S_PLACE) begin
         failures++;
         $display("FAIL place_hold: state=%0d required=%0d", state, S_PLACE);
      end
   endtask

   task automatic test_place_and_shot();
      bit stable = 1'b1;
      go_pturn();
      checks++;
      if (timer !== RELOAD) begin
         failures++;
         $display("FAIL timer_load: timer=%0d required=%0d", timer, RELOAD);
      end
      // out-of-range cursors and a stray ack are ignored
      cur_x = 3'd5; cur_y = 3'd2; confirm = 1'b1; cyc();
      cur_x = 3'd2; cur_y = 3'd7; cyc(); confirm = 1'b0;
      ack(1'b1);
      checks++;
      if (state !== S_P_TURN || shot_valid !== 1'b0) begin
         failures++;
         $display("FAIL bad_cursor_ignored: state=%0d valid=%0b required state=%0d valid=0",
                  state, shot_valid, S_P_TURN);
      end
      fire(3'd2, 3'd3);
      repeat (3) begin
         cyc();
         if (shot_valid !== 1'b1 || shot_to_enemy !== 1'b1 || shot_x !== 3'd2 || shot_y !== 3'd3) stable = 1'b0;
      end
      checks++;
      if (!stable) begin
         failures++;
         $display("FAIL shot_stable: valid=%0b (%0d,%0d) required valid=1 (2,3)", shot_valid, shot_x, shot_y);
      end
      ack(1'b0);
      checks++;
      if (shot_valid !== 1'b0 || state !== S_E_WAIT) begin
         failures++;
         $display("FAIL ack_to_ewait: valid=%0b state=%0d required valid=0 state=%0d", shot_valid, state, S_E_WAIT);
      end
   endtask

   task automatic test_timeout();
      go_pturn();
      if (TMO) begin
         for (int i = 1; i <= 10; i++) begin
            pulse_tick();
            checks++;
            if (timer !== 4'(10 - i) || state !== ((i < 10) ? S_P_TURN : S_E_WAIT)) begin
               failures++;
               $display("FAIL timeout_tick%0d: timer=%0d state=%0d required timer=%0d", i, timer, state, 10 - i);
            end
         end
         go_pturn();
         repeat (9) pulse_tick();
         cur_x = 3'd1; cur_y = 3'd4;
         tick_1hz = 1'b1;
         fire(3'd1, 3'd4);
         tick_1hz = 1'b0;
      end else begin
         repeat (12) pulse_tick();
         checks++;
         if (timer !== 4'd0 || state !== S_P_TURN) begin
            failures++;
            $display("FAIL no_timeout: timer=%0d state=%0d required timer=0 state=%0d", timer, state, S_P_TURN);
         end
      end
   endtask

   task automatic test_repeat();
      logic [3:0] t_exp;
      bit ok;
      go_pturn();
      repeat (3) pulse_tick();
      t_exp = TMO ? 4'd7 : 4'd0;
      fire(3'd4, 3'd0);
      ack(1'b1);
      checks++;
      if (state !== S_P_TURN || timer !== t_exp || shot_valid !== 1'b0) begin
         failures++;
         $display("FAIL player_repeat: state=%0d timer=%0d required state=%0d timer=%0d", state, timer, S_P_TURN, t_exp);
      end
      fire(3'd0, 3'd4);
      ack(1'b0);
      enemy_shot(1'b1, 0);
      ack(1'b1);
      checks++;
      if (shot_valid !== 1'b0 || (state !== S_E_WAIT && state !== S_E_SHOT)) begin
         failures++;
         $display("FAIL enemy_repeat_ack: valid=%0b state=%0d required valid=0 state=%0d", shot_valid, state, S_E_WAIT);
      end
      enemy_shot(1'b0, 1);
      ack(1'b0);
      checks++;
      if (state !== S_P_TURN || timer !== RELOAD) begin
         failures++;
         $display("FAIL enemy_to_pturn: state=%0d timer=%0d required state=%0d timer=%0d", state, timer, S_P_TURN, RELOAD);
      end
      wait_state(S_P_TURN, 1, ok);
   endtask

   task automatic test_enemy_200();
      go_pturn();
      for (int i = 0; i < 200; i++) begin
         fire(3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)));
         ack(1'b0);
         enemy_shot(1'b1, i);
         ack(1'b0);
         checks++;
         if (state !== S_P_TURN) begin
            failures++;
            $display("FAIL enemy_loop%0d: state=%0d required=%0d", i, state, S_P_TURN);
            go_pturn();
         end
      end
   endtask

   task automatic test_win_loss();
      bit held = 1'b1;
      go_pturn();
      fire(3'd3, 3'd3);
      ack(1'b0);
      e_ships_left = 3'd0; p_ships_left = 3'd0;
      cyc();
      checks++;
      if (state !== S_WIN || game_over !== 1'b1 || winner !== 1'b1) begin
         failures++;
         $display("FAIL both_zero_win: state=%0d over=%0b winner=%0b required state=%0d over=1 winner=1",
                  state, game_over, winner, S_WIN);
      end
      e_ships_left = 3'd5; p_ships_left = 3'd5;
      for (int i = 0; i < 10; i++) begin
         confirm = 1'b1; tick_1hz = 1'b1; shot_ack = 1'b1; cyc();
         if (state !== S_WIN || game_over !== 1'b1 || winner !== 1'b1) held = 1'b0;
      end
      confirm = 1'b0; tick_1hz = 1'b0; shot_ack = 1'b0;
      checks++;
      if (!held) begin
         failures++;
         $display("FAIL win_absorbing: state=%0d required=%0d", state, S_WIN);
      end
      // loss in P_TURN outranks a simultaneous valid confirm
      go_pturn();
      p_ships_left = 3'd0; cur_x = 3'd1; cur_y = 3'd1; confirm = 1'b1;
      cyc();
      confirm = 1'b0;
      checks++;
      if (state !== S_LOSE || game_over !== 1'b1 || winner !== 1'b0 || shot_valid !== 1'b0) begin
         failures++;
         $display("FAIL lose: state=%0d over=%0b winner=%0b required state=%0d over=1 winner=0",
                  state, game_over, winner, S_LOSE);
      end
      p_ships_left = 3'd5;
   endtask

   task automatic test_reset_mid_shot();
      go_pturn();
      fire(3'd2, 3'd1);
      #5 reset = 1'b0;
      #1;
      checks++;
      if (shot_valid !== 1'b0 || state !== S_IDLE) begin
         failures++;
         $display("FAIL async_reset: valid=%0b state=%0d required valid=0 state=0", shot_valid, state);
      end
      cyc();
      reset = 1'b1;
      #1;
      checks++;
      if (state !== S_IDLE || dut.u_lfsr.q !== 8'h5A || game_over !== 1'b0) begin
         failures++;
         $display("FAIL after_release: state=%0d lfsr=%h required state=0 lfsr=5a", state, dut.u_lfsr.q);
      end
   endtask

   initial begin
      test_reset();
      test_place_and_shot();
      test_timeout();
      test_repeat();
      test_enemy_200();
      test_win_loss();
      test_reset_mid_shot();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
